// File: rtl/auth_pkg.sv
// Shared types and default parameters for the code-lock controller.
package auth_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      CHECK    = 3'd2,
      UNLOCKED = 3'd3,
      LOCKOUT  = 3'd4
   } auth_state_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_MAX_TRIES   = 3;
   localparam int DEF_LOCK_CYCLES = 16;

endpackage

// File: rtl/auth_compare.sv
// Combinational WIDTH-bit equality of stored code and guess.
module auth_compare #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] code,
   input  logic [WIDTH-1:0] guess,
   output logic             eq
);

   // Equal only when every bit position agrees.
   assign eq = &(~(code ^ guess));

endmodule

// File: rtl/auth_lock_controller.sv
// Code lock sequencer: stores a code, evaluates guesses, counts failures and
// enforces a timed lockout once the failure budget is exhausted.
module auth_lock_controller
   import auth_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MAX_TRIES   = DEF_MAX_TRIES,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           set_valid,
   input  logic [WIDTH-1:0]               set_code,
   input  logic                           guess_valid,
   input  logic [WIDTH-1:0]               guess_code,
   input  logic                           clear,
   output logic                           matched,
   output logic                           unmatched,
   output logic                           armed,
   output logic                           unlocked,
   output logic                           locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

   localparam int TW  = $clog2(MAX_TRIES + 1);
   localparam int TMW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   auth_state_t      state_q, state_d;
   logic [WIDTH-1:0] code_q, code_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [TW-1:0]    tries_q, tries_d;
   logic [TMW-1:0]   timer_q, timer_d;
   logic             matched_q, matched_d;
   logic             unmatched_q, unmatched_d;
   logic             armed_q, armed_d;
   logic             unlocked_q, unlocked_d;
   logic             locked_out_q, locked_out_d;
   logic             eq;

   auth_compare #(.WIDTH(WIDTH)) u_cmp (
      .code  (code_q),
      .guess (guess_q),
      .eq    (eq)
   );

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      guess_d     = guess_q;
      tries_d     = tries_q;
      timer_d     = timer_q;
      matched_d   = 1'b0;
      unmatched_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (set_valid) begin
               code_d  = set_code;
               tries_d = TW'(MAX_TRIES);
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (guess_valid) begin
               guess_d = guess_code;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (eq) begin
               matched_d = 1'b1;
               state_d   = UNLOCKED;
            end else begin
               unmatched_d = 1'b1;
               if (tries_q != '0)
                  tries_d = tries_q - TW'(1);
               // Last allowed failure (or none left) drops straight into lockout.
               if (tries_q <= TW'(1)) begin
                  state_d = LOCKOUT;
                  timer_d = TMW'(LOCK_CYCLES - 1);
               end else begin
                  state_d = ARMED;
               end
            end
         end
         UNLOCKED: begin
            if (clear) begin
               code_d  = '0;
               tries_d = '0;
               state_d = IDLE;
            end else if (set_valid) begin
               code_d  = set_code;
               tries_d = TW'(MAX_TRIES);
               state_d = ARMED;
            end
         end
         LOCKOUT: begin
            if (timer_q == '0) begin
               tries_d = TW'(MAX_TRIES);
               state_d = ARMED;
            end else begin
               timer_d = timer_q - TMW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Status flags are decoded from the next state so they register in step.
      armed_d      = (state_d == ARMED) || (state_d == CHECK);
      unlocked_d   = (state_d == UNLOCKED);
      locked_out_d = (state_d == LOCKOUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         code_q       <= '0;
         guess_q      <= '0;
         tries_q      <= '0;
         timer_q      <= '0;
         matched_q    <= 1'b0;
         unmatched_q  <= 1'b0;
         armed_q      <= 1'b0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         guess_q      <= guess_d;
         tries_q      <= tries_d;
         timer_q      <= timer_d;
         matched_q    <= matched_d;
         unmatched_q  <= unmatched_d;
         armed_q      <= armed_d;
         unlocked_q   <= unlocked_d;
         locked_out_q <= locked_out_d;
      end
   end

   assign matched    = matched_q;
   assign unmatched  = unmatched_q;
   assign armed      = armed_q;
   assign unlocked   = unlocked_q;
   assign locked_out = locked_out_q;
   assign tries_left = tries_q;

endmodule
